// File: rtl/dffram_arb_pkg.sv
// Shared types and constants for the two-port DFFRAM arbiter.
package dffram_arb_pkg;

    typedef enum logic {
        ARB  = 1'b0,
        HOLD = 1'b1
    } arb_state_t;

    localparam int GCNT_W = 16;

endpackage

// File: rtl/dffram_arbiter.sv
// Two-port round-robin arbiter with lock/burst limit in front of an external DFFRAM macro.
// Optional saturating per-port grant counters (GCNT0/GCNT1) when DFFRAM_ARB_STATS_EN is defined.
module dffram_arbiter
    import dffram_arb_pkg::*;
#(
    parameter int AW        = 8,
    parameter int WSIZE     = 4,
    parameter int MAX_BURST = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 REQ0,
    input  logic                 LOCK0,
    input  logic [WSIZE-1:0]     WE0,
    input  logic [AW-1:0]        A0,
    input  logic [8*WSIZE-1:0]   DI0,
    output logic                 GNT0,
    output logic                 RVALID0,
    output logic [8*WSIZE-1:0]   DO0,
    input  logic                 REQ1,
    input  logic                 LOCK1,
    input  logic [WSIZE-1:0]     WE1,
    input  logic [AW-1:0]        A1,
    input  logic [8*WSIZE-1:0]   DI1,
    output logic                 GNT1,
    output logic                 RVALID1,
    output logic [8*WSIZE-1:0]   DO1,
`ifdef DFFRAM_ARB_STATS_EN
    output logic [GCNT_W-1:0]    GCNT0,
    output logic [GCNT_W-1:0]    GCNT1,
`endif
    output logic                 RAM_EN,
    output logic [WSIZE-1:0]     RAM_WE,
    output logic [AW-1:0]        RAM_A,
    output logic [8*WSIZE-1:0]   RAM_DI,
    input  logic [8*WSIZE-1:0]   RAM_DO
);

    localparam int BW = $clog2(MAX_BURST) + 1;
    localparam logic [BW-1:0] LIMIT = BW'(MAX_BURST - 1);

    arb_state_t          state_q, state_d;
    logic                owner_q, owner_d;
    logic                last_q, last_d;
    logic [BW-1:0]       burst_q, burst_d;
    logic                rvalid0_q, rvalid0_d;
    logic                rvalid1_q, rvalid1_d;
    logic [8*WSIZE-1:0]  do0_q, do0_d;
    logic [8*WSIZE-1:0]  do1_q, do1_d;

    logic                win;
    logic                win_valid;
    logic                other_req;
    logic                win_lock;
    logic [BW-1:0]       cnt_next;

    always_comb begin
        win       = 1'b0;
        win_valid = 1'b0;
        if (state_q == HOLD) begin
            win       = owner_q;
            win_valid = owner_q ? REQ1 : REQ0;
        end else begin
            win       = (REQ0 && REQ1) ? ~last_q : REQ1;
            win_valid = REQ0 | REQ1;
        end

        other_req = win ? REQ0 : REQ1;
        win_lock  = win ? LOCK1 : LOCK0;
        // The run length counts the lock-entry grant too, so the owner gets MAX_BURST-1 grants in a row.
        cnt_next  = ((state_q == HOLD) ? burst_q : '0) + BW'(other_req);

        state_d = ARB;
        owner_d = owner_q;
        last_d  = last_q;
        burst_d = '0;
        if (win_valid) begin
            last_d = win;
            if (win_lock && (cnt_next < LIMIT)) begin
                state_d = HOLD;
                owner_d = win;
                burst_d = cnt_next;
            end
        end

        GNT0 = win_valid & ~win;
        GNT1 = win_valid & win;

        RAM_EN = win_valid;
        RAM_WE = win_valid ? (win ? WE1 : WE0) : '0;
        RAM_A  = win ? A1 : A0;
        RAM_DI = win ? DI1 : DI0;

        rvalid0_d = GNT0 & ~(|WE0);
        rvalid1_d = GNT1 & ~(|WE1);
        // RAM_DO is valid the cycle after the grant; pass it through then and hold it afterwards.
        do0_d = rvalid0_q ? RAM_DO : do0_q;
        do1_d = rvalid1_q ? RAM_DO : do1_q;
    end

    assign RVALID0 = rvalid0_q;
    assign RVALID1 = rvalid1_q;
    assign DO0     = do0_d;
    assign DO1     = do1_d;

`ifdef DFFRAM_ARB_STATS_EN
    logic [GCNT_W-1:0] gcnt0_q, gcnt0_d;
    logic [GCNT_W-1:0] gcnt1_q, gcnt1_d;

    always_comb begin
        gcnt0_d = (GNT0 && (gcnt0_q != '1)) ? gcnt0_q + 1'b1 : gcnt0_q;
        gcnt1_d = (GNT1 && (gcnt1_q != '1)) ? gcnt1_q + 1'b1 : gcnt1_q;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            gcnt0_q <= '0;
            gcnt1_q <= '0;
        end else begin
            gcnt0_q <= gcnt0_d;
            gcnt1_q <= gcnt1_d;
        end
    end

    assign GCNT0 = gcnt0_q;
    assign GCNT1 = gcnt1_q;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= ARB;
            owner_q   <= 1'b0;
            last_q    <= 1'b1;
            burst_q   <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            do0_q     <= '0;
            do1_q     <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            burst_q   <= burst_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
            do0_q     <= do0_d;
            do1_q     <= do1_d;
        end
    end

endmodule

// File: doc/dffram_arbiter.md
DFFRAM_ARBITER -- requirements
Module: dffram_arbiter

Interface
REQ-001 SHALL have parameter AW, default 8, RAM word-address width.
REQ-002 SHALL have parameter WSIZE, default 4, byte lanes; data width is 8*WSIZE.
REQ-003 SHALL have parameter MAX_BURST, default 8, maximum consecutive grants to one locked port while the other port requests.
REQ-004 SHALL have port CLK, input, 1, single clock; all state updates on its rising edge.
REQ-005 SHALL have port RST, input, 1; reset is asynchronous and active-high.
REQ-006 SHALL have ports REQn, input, 1, access request (n = 0, 1).
REQ-007 SHALL have ports LOCKn, input, 1, request to keep the grant on the next cycle.
REQ-008 SHALL have ports WEn, input, WSIZE, byte write enables; all-zero means read.
REQ-009 SHALL have ports An, input, AW, word address.
REQ-010 SHALL have ports DIn, input, 8*WSIZE, write data.
REQ-011 SHALL have ports GNTn, output, 1, request accepted this cycle.
REQ-012 SHALL have ports RVALIDn, output, 1, read data valid on DOn.
REQ-013 SHALL have ports DOn, output, 8*WSIZE, read data.
REQ-014 SHALL have RAM-side ports RAM_EN (output, 1), RAM_WE (output, WSIZE), RAM_A (output, AW), RAM_DI (output, 8*WSIZE) and RAM_DO (input, 8*WSIZE).

Function
REQ-015 SHALL be combinational on grant: GNTn is asserted in the same cycle as REQn when port n wins; at most one GNT is high per cycle.
REQ-016 SHALL drive RAM_EN = GNT0|GNT1 and route the winner's WE, A and DI to the RAM; when neither port is granted, RAM_EN=0 and RAM_WE=0.
REQ-017 SHALL arbitrate round-robin: when both ports request with no lock in force, the port not granted last wins; the last-grant pointer resets to port 1, so port 0 wins first.
REQ-018 SHALL use two states, ARB (free) and HOLD (locked to the owner port).
REQ-019 SHALL enter HOLD when a granted port asserts LOCKn, and return to ARB when the owner drops LOCKn or REQn.
REQ-020 SHALL, in HOLD, grant only the owner; a burst counter increments on each owner grant while the other port requests.
REQ-021 SHALL, when the burst counter reaches MAX_BURST-1, force a return to ARB and grant the other port next, regardless of LOCK; the counter clears on leaving HOLD.
REQ-022 SHALL, for a granted read (WE=0), assert RVALIDn for exactly one cycle, one cycle after the grant, with DOn = RAM_DO; a granted write produces no RVALID.
REQ-023 SHALL hold DOn at its last value otherwise; DOn is not forwarded to the non-owner port.
REQ-024 SHALL keep reads and writes to the same address in back-to-back cycles in order (no reordering; write-then-read returns new data).
REQ-025 SHALL keep GNT and RVALID low for a port whose REQ is low.

Reset
REQ-026 SHALL, on RST assertion, immediately force state ARB, last-grant pointer=1, burst counter=0, RVALID0/1=0, DO0/1=0, with no wait for a CLK edge.
REQ-027 SHALL discard a read in flight when reset is asserted mid-operation; no RVALID follows reset deassertion.

Configuration
REQ-028 SHALL, with DFFRAM_ARB_STATS_EN defined, add outputs GCNT0 and GCNT1 (16 bits each): saturating per-port grant counters, cleared by RST.
REQ-029 SHALL, without DFFRAM_ARB_STATS_EN, omit those ports and counters; all other behaviour is identical.

Structure
REQ-030 SHALL place the state enum (ARB, HOLD) and the grant-counter width constant in package dffram_arb_pkg.
REQ-031 SHALL be a single module with no sub-modules; it instantiates no RAM and connects externally to a DFFRAM macro.

Verification
REQ-032 SHALL test single port: REQ0 read A0=0x10, RAM_DO=0xDEADBEEF -> GNT0 in cycle 0, RVALID0=1 and DO0=0xDEADBEEF in cycle 1.
REQ-033 SHALL test contention: both ports request continuously without lock after reset -> grants alternate 0,1,0,1.
REQ-034 SHALL test lock starvation guard: MAX_BURST=8, port 0 locked, port 1 requesting -> port 0 receives 7 grants, then port 1 is granted.
REQ-035 SHALL test a byte write: REQ1 WE1=4'b0010, A1=0x3F, DI1=0x0000AB00 -> RAM_EN=1, RAM_WE=0010, RAM_A=0x3F, no RVALID1.
REQ-036 SHALL test mid-read reset: RST asserted the cycle after a read grant -> RVALID and DO are 0 immediately and stay 0 after release.
REQ-037 SHALL test stats, with DFFRAM_ARB_STATS_EN: 70000 port-0 grants -> GCNT0 saturates at 0xFFFF.
